fifo_stream_out: RTL and testbench

- Downstream drain stage for the team's FIFO read port.
- Pops words from the FIFO using its rd_en/rd_data/empty interface and presents them on a valid/ready stream.
- A small internal buffer absorbs the one-cycle FIFO read latency, so the stream sustains 1 beat/cycle and never drops or duplicates a word under back-pressure.
- Runs on the FIFO read clock.

---
 rtl/fifo_stream_out_pkg.sv | 21 ++
 rtl/fifo_stream_out_if.sv | 42 ++++
 rtl/fifo_stream_out_stream_buffer.sv | 56 +++++
 rtl/fifo_stream_out.sv | 78 +++++++
 tb/tb_fifo_stream_out.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_stream_out_pkg.sv
// fifo_stream_out_pkg
//   Shared definitions for the FIFO stream drain stage: the clog2 helper used
//   to size pointers and counters, and the legal range of BUF_DEPTH.
//   No ports (package).
//   Optional feature macro used by the top: FIFO_STREAM_OUT_BEAT_CNT_EN.
package fifo_stream_out_pkg;

  localparam int BUF_DEPTH_MIN = 2;
  localparam int BUF_DEPTH_MAX = 16;

  // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(3) = 2.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_stream_out_if.sv
// fifo_stream_out_if
//   Bundles the FIFO read-port signals and the valid/ready output stream.
//   Signals:
//     fifo_rd_data  FIFO read data (valid the cycle after fifo_rd_en)
//     fifo_empty    FIFO empty flag
//     fifo_rd_en    FIFO pop request
//     m_data        stream data
//     m_valid       stream data valid
//     m_ready       stream consumer ready
//   Modports:
//     master  the drain stage (drives fifo_rd_en and the stream)
//     slave   the FIFO plus stream consumer side
interface fifo_stream_out_if #(
  parameter int DATA_WIDTH = 1
);

  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;

  modport master (
    input  fifo_rd_data,
    input  fifo_empty,
    input  m_ready,
    output fifo_rd_en,
    output m_data,
    output m_valid
  );

  modport slave (
    output fifo_rd_data,
    output fifo_empty,
    output m_ready,
    input  fifo_rd_en,
    input  m_data,
    input  m_valid
  );

endinterface

// File: rtl/fifo_stream_out_stream_buffer.sv
// stream_buffer
//   Circular output buffer of BUF_DEPTH words. Depth need not be a power of
//   two; pointers wrap explicitly from BUF_DEPTH-1 to 0.
//   Ports:
//     clk        clock, rising edge
//     reset      asynchronous active-low reset (clears pointers and contents)
//     push       write push_data at tail
//     push_data  word to store
//     pop        advance head
//     head_data  word at head (the stream data)
//     occ        number of stored words, 0..BUF_DEPTH
//   The caller guarantees no push when full and no pop when empty.
module stream_buffer
  import fifo_stream_out_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int BUF_DEPTH  = 2,
  localparam int PTR_W     = clog2(BUF_DEPTH),
  localparam int OCC_W     = clog2(BUF_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [OCC_W-1:0]      occ
);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(BUF_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[tail] <= push_data;
        tail      <= next_ptr(tail);
      end
      if (pop) head <= next_ptr(head);
      occ <= occ + OCC_W'(push) - OCC_W'(pop);
    end
  end

  assign head_data = mem[head];

endmodule

// File: rtl/fifo_stream_out.sv
// fifo_stream_out
//   Drains a FIFO read port (rd_en / rd_data one cycle later / empty) onto a
//   valid/ready stream at up to one beat per cycle. The output buffer absorbs
//   the FIFO read latency; a credit check keeps buffered plus in-flight words
//   within BUF_DEPTH, so nothing is dropped or duplicated under back-pressure.
//   Ports:
//     clk         FIFO read clock, rising edge
//     reset       asynchronous active-low reset
//     bus         fifo_stream_out_if.master (FIFO read port + output stream)
//     beat_count  completed handshakes, wraps; only with
//                 FIFO_STREAM_OUT_BEAT_CNT_EN defined
//   Optional feature macro: FIFO_STREAM_OUT_BEAT_CNT_EN.
module fifo_stream_out
  import fifo_stream_out_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int BUF_DEPTH  = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  fifo_stream_out_if.master    bus
`ifdef FIFO_STREAM_OUT_BEAT_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] beat_count
`endif
);

  localparam int OCC_W = clog2(BUF_DEPTH + 1);
  localparam int CR_W  = OCC_W + 1;

  if (BUF_DEPTH < BUF_DEPTH_MIN || BUF_DEPTH > BUF_DEPTH_MAX) begin : g_bad_depth
    $error("fifo_stream_out: BUF_DEPTH out of range");
  end
  if (CNT_WIDTH < 1) begin : g_bad_cnt
    $error("fifo_stream_out: CNT_WIDTH must be at least 1");
  end

  logic             inflight;
  logic             pop;
  logic [OCC_W-1:0] occ;
  logic [CR_W-1:0]  credit;

  assign bus.m_valid = (occ != '0);
  assign pop         = bus.m_valid & bus.m_ready;

  // Occupancy one cycle ahead. Counting this cycle's pop lets a read issue
  // while the buffer is full-but-draining, which sustains one beat per cycle.
  assign credit = CR_W'(occ) + CR_W'(inflight) - CR_W'(pop);

  assign bus.fifo_rd_en = reset & ~bus.fifo_empty & (credit < CR_W'(BUF_DEPTH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) inflight <= 1'b0;
    else        inflight <= bus.fifo_rd_en;
  end

  stream_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight),
    .push_data (bus.fifo_rd_data),
    .pop       (pop),
    .head_data (bus.m_data),
    .occ       (occ)
  );

`ifdef FIFO_STREAM_OUT_BEAT_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   beat_count <= '0;
    else if (pop) beat_count <= beat_count + CNT_WIDTH'(1);
  end
`endif

endmodule

// File: tb/tb_fifo_stream_out.sv
module tb_fifo_stream_out;

  typedef struct {
    logic       ready;
    logic       rd_en;
    logic       valid;
    logic [7:0] data;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  fifo_stream_out_if #(.DATA_WIDTH(8)) bus ();

`ifdef FIFO_STREAM_OUT_BEAT_CNT_EN
  logic [3:0] beat_count;
`endif

  fifo_stream_out #(
    .DATA_WIDTH (8),
    .BUF_DEPTH  (2),
    .CNT_WIDTH  (4)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
`ifdef FIFO_STREAM_OUT_BEAT_CNT_EN
    ,
    .beat_count (beat_count)
`endif
  );

  // FIFO model: one-cycle read latency, empty when all loaded words are read.
  logic [7:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;

  assign bus.fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (bus.fifo_rd_en) begin
      bus.fifo_rd_data <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr] = first + 8'(i);
      wr_ptr = wr_ptr + 1;
    end
  endtask

  // Applies one per-cycle vector at negedge+1 and advances to the next negedge.
  task automatic run_vec(input string tag, input int idx, input vec_t v);
    bus.m_ready = v.ready;
    #1;
    chk($sformatf("%s[%0d].rd_en", tag, idx), 32'(bus.fifo_rd_en), 32'(v.rd_en));
    chk($sformatf("%s[%0d].valid", tag, idx), 32'(bus.m_valid), 32'(v.valid));
    if (v.valid) chk($sformatf("%s[%0d].data", tag, idx), 32'(bus.m_data), 32'(v.data));
    @(negedge clk);
  endtask

  vec_t stream_v [11];
  vec_t stall_v  [17];

  initial begin
    int   got;
    int   idx;
    int   outstanding;
    logic tog;
    logic pop;

    // cycle N counted from the negedge where reset is released
    stream_v[0]  = '{1'b1, 1'b1, 1'b0, 8'h00};
    stream_v[1]  = '{1'b1, 1'b1, 1'b0, 8'h00};
    stream_v[2]  = '{1'b1, 1'b1, 1'b1, 8'h01};
    stream_v[3]  = '{1'b1, 1'b1, 1'b1, 8'h02};
    stream_v[4]  = '{1'b1, 1'b1, 1'b1, 8'h03};
    stream_v[5]  = '{1'b1, 1'b1, 1'b1, 8'h04};
    stream_v[6]  = '{1'b1, 1'b1, 1'b1, 8'h05};
    stream_v[7]  = '{1'b1, 1'b1, 1'b1, 8'h06};
    stream_v[8]  = '{1'b1, 1'b0, 1'b1, 8'h07};
    stream_v[9]  = '{1'b1, 1'b0, 1'b1, 8'h08};
    stream_v[10] = '{1'b1, 1'b0, 1'b0, 8'h00};

    stall_v[0]  = '{1'b1, 1'b1, 1'b0, 8'h00};
    stall_v[1]  = '{1'b1, 1'b1, 1'b0, 8'h00};
    stall_v[2]  = '{1'b0, 1'b0, 1'b1, 8'h01};
    stall_v[3]  = '{1'b0, 1'b0, 1'b1, 8'h01};
    stall_v[4]  = '{1'b0, 1'b0, 1'b1, 8'h01};
    stall_v[5]  = '{1'b0, 1'b0, 1'b1, 8'h01};
    stall_v[6]  = '{1'b0, 1'b0, 1'b1, 8'h01};
    stall_v[7]  = '{1'b0, 1'b0, 1'b1, 8'h01};
    stall_v[8]  = '{1'b0, 1'b0, 1'b1, 8'h01};
    stall_v[9]  = '{1'b0, 1'b0, 1'b1, 8'h01};
    stall_v[10] = '{1'b1, 1'b1, 1'b1, 8'h01};
    stall_v[11] = '{1'b1, 1'b1, 1'b1, 8'h02};
    stall_v[12] = '{1'b1, 1'b1, 1'b1, 8'h03};
    stall_v[13] = '{1'b1, 1'b1, 1'b1, 8'h04};
    stall_v[14] = '{1'b1, 1'b0, 1'b1, 8'h05};
    stall_v[15] = '{1'b1, 1'b0, 1'b1, 8'h06};
    stall_v[16] = '{1'b1, 1'b0, 1'b0, 8'h00};

    // Reset held with a non-empty FIFO
    rst_n = 1'b0;
    bus.m_ready = 1'b1;
    load(8'h01, 8);
    repeat (3) @(negedge clk);
    #1;
    chk("reset.rd_en", 32'(bus.fifo_rd_en), 32'd0);
    chk("reset.valid", 32'(bus.m_valid), 32'd0);
    chk("reset.data",  32'(bus.m_data),  32'd0);
`ifdef FIFO_STREAM_OUT_BEAT_CNT_EN
    chk("reset.beat_count", 32'(beat_count), 32'd0);
`endif

    // Streaming 01..08 with m_ready=1
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 11; i++) run_vec("stream", i, stream_v[i]);
`ifdef FIFO_STREAM_OUT_BEAT_CNT_EN
    chk("stream.beat_count", 32'(beat_count), 32'd8);
`endif

    // Stall with six words queued
    rst_n = 1'b0;
    load(8'h01, 6);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) run_vec("stall", i, stall_v[i]);

    // Async reset while the buffer holds two words
    rst_n = 1'b0;
    load(8'hA1, 4);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      bus.m_ready = 1'b0;
      #1;
      if (c == 3) begin
        chk("mid.full_valid", 32'(bus.m_valid), 32'd1);
        chk("mid.full_data",  32'(bus.m_data),  32'hA1);
        chk("mid.full_rd_en", 32'(bus.fifo_rd_en), 32'd0);
      end else begin
        @(negedge clk);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid.async_valid", 32'(bus.m_valid), 32'd0);
    chk("mid.async_data",  32'(bus.m_data),  32'd0);
    chk("mid.async_rd_en", 32'(bus.fifo_rd_en), 32'd0);
`ifdef FIFO_STREAM_OUT_BEAT_CNT_EN
    chk("mid.async_beat_count", 32'(beat_count), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    bus.m_ready = 1'b1;
    #1;
    chk("mid.release_valid", 32'(bus.m_valid), 32'd0);
    chk("mid.release_rd_en", 32'(bus.fifo_rd_en), 32'd1);
    got = 0;
    for (int c = 0; c < 20 && got < 2; c++) begin
      @(negedge clk);
      bus.m_ready = 1'b1;
      #1;
      if (bus.m_valid && bus.m_ready) begin
        chk("mid.drain_data", 32'(bus.m_data), 32'(8'hA3 + 8'(got)));
        got++;
      end
    end
    chk("mid.drain_count", 32'(got), 32'd2);
    @(negedge clk);
    #1;
    chk("mid.drained_valid", 32'(bus.m_valid), 32'd0);

    // Alternating m_ready over 16 words
    tog = 1'b1;
    idx = 0;
    outstanding = 0;
    for (int c = 0; c < 200 && idx < 16; c++) begin
      @(negedge clk);
      if (c == 0) load(8'h10, 16);
      bus.m_ready = tog;
      tog = ~tog;
      #1;
      pop = bus.m_valid & bus.m_ready;
      chk("alt.outstanding_le_2", 32'(outstanding <= 2), 32'd1);
      if (bus.fifo_rd_en) chk("alt.credit", 32'(outstanding - int'(pop) < 2), 32'd1);
      if (pop) begin
        chk("alt.data", 32'(bus.m_data), 32'(8'h10 + 8'(idx)));
        idx++;
      end
      outstanding = outstanding + int'(bus.fifo_rd_en) - int'(pop);
    end
    chk("alt.count", 32'(idx), 32'd16);
    @(negedge clk);
    #1;
    chk("alt.end_valid", 32'(bus.m_valid), 32'd0);
    chk("alt.end_rd_en", 32'(bus.fifo_rd_en), 32'd0);
`ifdef FIFO_STREAM_OUT_BEAT_CNT_EN
    chk("alt.beat_count_wrap", 32'(beat_count), 32'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
